// File: rtl/jedro_1_ifu.sv
// ============================================================================
// jedro_1_ifu -- instruction fetch unit for the jedro_1 core.
//
// Issues sequential word fetches to a synchronous ROM (1-cycle read latency),
// buffers the returned words together with their PCs in a small prefetch
// FIFO and presents the FIFO head to the decoder with a valid/ready handshake.
// A taken branch/jump redirect flushes the FIFO, kills any in-flight
// response and restarts fetching at the target address.
//
// Optional feature macro: JEDRO_1_IFU_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned target raises a sticky
//               misalign_o and halts fetching until an aligned redirect.
//   undefined : the low two target bits are ignored, misalign_o is tied 0.
// ============================================================================
module jedro_1_ifu #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
   parameter int                    FIFO_DEPTH = 4
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   // ROM read port
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   // redirect from the ALU stage
   input  logic                  jmp_instr_i,
   input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
   // decoder side
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  misalign_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]      DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [ADDR_WIDTH-1:0] fetch_pc_reg;
   logic [ADDR_WIDTH-1:0] fetch_pc_next;
   logic                  inflight_reg;
   logic                  inflight_next;
   logic [ADDR_WIDTH-1:0] inflight_pc_reg;
   logic [ADDR_WIDTH-1:0] inflight_pc_next;
   logic [PTR_W-1:0]      wr_ptr_reg;
   logic [PTR_W-1:0]      wr_ptr_next;
   logic [PTR_W-1:0]      rd_ptr_reg;
   logic [PTR_W-1:0]      rd_ptr_next;
   logic [CNT_W-1:0]      count_reg;
   logic [CNT_W-1:0]      count_next;

   // prefetch storage: one instruction word and its PC per entry
   logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

   // -------------------------------------------------------------------------
   // Control
   // -------------------------------------------------------------------------
   logic                  halt;        // fetch stopped by a misaligned target
   logic [ADDR_WIDTH-1:0] jmp_tgt;     // effective redirect target
   logic [CNT_W:0]        occupancy;   // buffered words plus the one in flight
   logic                  issue;
   logic                  push;
   logic                  pop;

`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
   logic misalign_reg;

   assign jmp_tgt    = jmp_addr_i;
   assign halt       = misalign_reg;
   assign misalign_o = misalign_reg;

   // Sticky flag: set by a misaligned redirect, cleared by the next aligned one
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         misalign_reg <= 1'b0;
      end else if (jmp_instr_i) begin
         misalign_reg <= |jmp_addr_i[1:0];
      end
   end
`else
   // Targets are always treated as word aligned.
   assign jmp_tgt    = {jmp_addr_i[ADDR_WIDTH-1:2], jmp_addr_i[1:0] & 2'b00};
   assign halt       = 1'b0;
   assign misalign_o = 1'b0;
`endif

   // Handshake decode: issue only when the FIFO can absorb the response,
   // never during a redirect; a redirect kills the response arriving now.
   always_comb begin
      occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
      issue     = !jmp_instr_i && !halt && (occupancy < DEPTH_C);
      push      = inflight_reg && !jmp_instr_i;
      pop       = (count_reg != '0) && ready_i;
   end

   // Next-state for fetch address, in-flight tracking and FIFO pointers
   always_comb begin
      fetch_pc_next    = fetch_pc_reg;
      inflight_next    = issue;
      inflight_pc_next = inflight_pc_reg;
      wr_ptr_next      = wr_ptr_reg;
      rd_ptr_next      = rd_ptr_reg;
      count_next       = count_reg;

      if (issue) begin
         fetch_pc_next    = fetch_pc_reg + PC_STEP;   // wraps modulo 2^ADDR_WIDTH
         inflight_pc_next = fetch_pc_reg;
      end

      if (jmp_instr_i) begin
         // A pop in this cycle was accepted by the decoder; the flush
         // discards everything else that is buffered.
         fetch_pc_next = jmp_tgt;
         wr_ptr_next   = '0;
         rd_ptr_next   = '0;
         count_next    = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         fetch_pc_reg    <= BOOT_ADDR;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         count_reg       <= '0;
      end else begin
         fetch_pc_reg    <= fetch_pc_next;
         inflight_reg    <= inflight_next;
         inflight_pc_reg <= inflight_pc_next;
         wr_ptr_reg      <= wr_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         count_reg       <= count_next;
      end
   end

   // Prefetch storage: the ROM response is captured with its tag PC at the tail
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
      end else if (push) begin
         instr_mem[wr_ptr_reg] <= mem_rdata_i;
         pc_mem[wr_ptr_reg]    <= inflight_pc_reg;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign mem_addr_o = fetch_pc_reg;
   assign instr_o    = instr_mem[rd_ptr_reg];
   assign pc_o       = pc_mem[rd_ptr_reg];
   assign valid_o    = (count_reg != '0);

endmodule

// File: tb/tb_jedro_1_ifu.sv
// ============================================================================
// tb_jedro_1_ifu -- directed self-checking bench for jedro_1_ifu.
//
// ROM model: word at byte address a is a>>2. Expected PCs are queued when a
// stream is started (reset or redirect) and popped on every decoder transfer.
// Build with +define+JEDRO_1_IFU_MISALIGN_CHK_EN to exercise the misalign path.
// ============================================================================
`timescale 1ns/1ps
module tb_jedro_1_ifu;

   logic        clk;
   logic        rstn;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        jmp_instr;
   logic [31:0] jmp_addr;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;
   logic        ready;
   logic        misalign;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb [$];

   jedro_1_ifu dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata),
      .jmp_instr_i (jmp_instr),
      .jmp_addr_i  (jmp_addr),
      .instr_o     (instr),
      .pc_o        (pc),
      .valid_o     (valid),
      .ready_i     (ready),
      .misalign_o  (misalign)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous ROM, one cycle read latency
   always @(posedge clk) mem_rdata <= {2'b00, mem_addr[31:2]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance to just after the next rising edge (drive/check point)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_stream(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
   endtask

   // scoreboard: every accepted word must be the next expected PC in order
   always @(negedge clk) begin
      if (rstn && valid && ready) begin
         n_tests++;
         assert (sb.size() != 0)
         else begin
            n_fail++;
            $error("FAIL xfer_unexpected: observed pc %h expected no transfer", pc);
         end
         if (sb.size() != 0) begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("xfer_pc", pc, e);
            chk("xfer_instr", instr, {2'b00, e[31:2]});
         end
      end
   end

   // global time bound
   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   task automatic do_reset(input logic rdy);
      rstn      = 1'b0;
      jmp_instr = 1'b0;
      jmp_addr  = '0;
      ready     = rdy;
      sb.delete();
      step();
      step();
      push_stream(32'h0, 64);
      rstn = 1'b1;            // cycle C0 starts here
   endtask

   initial begin
      rstn      = 1'b0;
      jmp_instr = 1'b0;
      jmp_addr  = '0;
      ready     = 1'b0;
      #2;
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_misalign", 32'(misalign), 32'h0);

      // ---- 1: first-fetch latency and back-to-back throughput -------------
      do_reset(1'b1);
      step();                                   // C1
      chk("t1_c1_valid", 32'(valid), 32'h0);
      step();                                   // C2
      chk("t1_c2_valid", 32'(valid), 32'h1);
      chk("t1_c2_pc", pc, 32'h0);
      for (int i = 1; i <= 5; i++) begin
         step();
         chk("t1_stream_valid", 32'(valid), 32'h1);
         chk("t1_stream_pc", pc, 32'(4 * i));
      end

      // ---- 2: decoder stalled, FIFO saturates without loss ----------------
      do_reset(1'b0);
      for (int i = 0; i < 12; i++) step();
      chk("t2_full_addr", mem_addr, 32'h10);
      chk("t2_full_valid", 32'(valid), 32'h1);
      chk("t2_full_pc", pc, 32'h0);
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_drain_valid", 32'(valid), 32'h1);
         step();
      end

      // ---- 3: redirect to 0x40 with a loaded FIFO --------------------------
      ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      jmp_instr = 1'b1;
      jmp_addr  = 32'h40;
      step();                                   // J+1
      jmp_instr = 1'b0;
      sb.delete();
      push_stream(32'h40, 32);
      chk("t3_j1_valid", 32'(valid), 32'h0);
      chk("t3_j1_addr", mem_addr, 32'h40);
      step();                                   // J+2
      chk("t3_j2_valid", 32'(valid), 32'h0);
      step();                                   // J+3
      chk("t3_j3_valid", 32'(valid), 32'h1);
      chk("t3_j3_pc", pc, 32'h40);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // ---- 4: redirect coincident with the pop of pc 0x8 --------------------
      do_reset(1'b0);
      for (int i = 0; i < 4; i++) step();
      ready = 1'b1;                             // pops 0x0
      step();                                   // pops 0x4
      step();
      chk("t4_pop_pc", pc, 32'h8);
      jmp_instr = 1'b1;                         // 0x8 accepted in this cycle
      jmp_addr  = 32'h80;
      step();
      jmp_instr = 1'b0;
      sb.delete();
      push_stream(32'h80, 32);
      chk("t4_j1_valid", 32'(valid), 32'h0);
      step();
      step();
      chk("t4_j3_pc", pc, 32'h80);
      for (int i = 0; i < 3; i++) step();

      // ---- 5: address wrap, then asynchronous reset mid-stream -------------
      jmp_instr = 1'b1;
      jmp_addr  = 32'hFFFF_FFFC;
      step();
      jmp_instr = 1'b0;
      sb.delete();
      push_stream(32'hFFFF_FFFC, 16);
      step();
      step();
      chk("t5_top_pc", pc, 32'hFFFF_FFFC);
      step();
      chk("t5_wrap_pc", pc, 32'h0);
      chk("t5_wrap_instr", instr, 32'h0);
      step();
      #2;
      rstn = 1'b0;                              // asynchronous, between edges
      #1;
      chk("t5_rst_valid", 32'(valid), 32'h0);
      chk("t5_rst_addr", mem_addr, 32'h0);
      chk("t5_rst_pc", pc, 32'h0);

      // ---- 6: misaligned redirect target -----------------------------------
      do_reset(1'b1);
      for (int i = 0; i < 5; i++) step();
      jmp_instr = 1'b1;
      jmp_addr  = 32'h42;
      step();                                   // J+1
      jmp_instr = 1'b0;
      sb.delete();
`ifdef JEDRO_1_IFU_MISALIGN_CHK_EN
      chk("t6_mis_set", 32'(misalign), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk("t6_mis_valid", 32'(valid), 32'h0);
         step();
      end
      chk("t6_mis_sticky", 32'(misalign), 32'h1);
      jmp_instr = 1'b1;
      jmp_addr  = 32'h44;
      step();                                   // J+1
      jmp_instr = 1'b0;
      push_stream(32'h44, 16);
      chk("t6_mis_clear", 32'(misalign), 32'h0);
      step();
      step();                                   // J+3
      chk("t6_j3_valid", 32'(valid), 32'h1);
      chk("t6_j3_pc", pc, 32'h44);
`else
      push_stream(32'h40, 16);
      chk("t6_mis_tied", 32'(misalign), 32'h0);
      chk("t6_forced_addr", mem_addr, 32'h40);
      step();
      step();                                   // J+3
      chk("t6_j3_valid", 32'(valid), 32'h1);
      chk("t6_j3_pc", pc, 32'h40);
`endif
      for (int i = 0; i < 3; i++) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
